mem_access_unit: RTL and testbench

//   Request/response front end that sits between the multicycle datapath/controller and the

---
 rtl/mem_access_unit.sv | 141 ++++++++++++++
 tb/tb_mem_access_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Word-memory front end: fetch, load and store with alignment/range checks, IR, load extension.
// Latency from acceptance: fetch/load 2, word store 2, sub-word store 3 (read-modify-write), error 1.
// Accepts one request at a time (req_ready only in IDLE); the response holds until resp_ready.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_type,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_err,
  output logic [31:0] rdata,
  output logic [31:0] ir,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [1:0] T_FETCH = 2'b00;
  localparam logic [1:0] T_LOAD  = 2'b01;
  localparam logic [1:0] T_STORE = 2'b10;
  localparam logic [1:0] S_BYTE  = 2'b00;
  localparam logic [1:0] S_HALF  = 2'b01;
  localparam logic [1:0] S_WORD  = 2'b10;

  state_t      state;
  logic [1:0]  reqType;
  logic [1:0]  reqSize;
  logic        reqSigned;
  logic [1:0]  reqOff;
  logic [15:0] reqWdata;

  logic        reqErr;
  logic [4:0]  laneShift;
  logic [31:0] laneWord;
  logic [31:0] laneMask;
  logic [31:0] loadVal;
  logic [31:0] mergeVal;

  // Handshake and memory strobe come straight from state so reset removes them immediately.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_write  = (state == WR);

  // Reject illegal encodings, misalignment and out-of-range addresses at the request port.
  always_comb begin
    reqErr = 1'b0;
    if (req_type == 2'b11) reqErr = 1'b1;
    if (req_type != T_FETCH && req_size == 2'b11) reqErr = 1'b1;
    if (req_type != T_FETCH && req_size == S_HALF && req_addr[0]) reqErr = 1'b1;
    if ((req_type == T_FETCH || req_size == S_WORD) && req_addr[1:0] != 2'b00) reqErr = 1'b1;
    if (req_addr >= 32'(MEM_BYTES)) reqErr = 1'b1;
  end

  // Big-endian lane select: byte k lives at [31-8k -: 8], half 0 at [31:16], half 2 at [15:0].
  always_comb begin
    laneShift = (reqSize == S_BYTE) ? {~reqOff, 3'b000} : (reqOff[1] ? 5'd0 : 5'd16);
    laneWord  = mem_rdata >> laneShift;
    laneMask  = ((reqSize == S_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << laneShift;
    mergeVal  = (mem_rdata & ~laneMask) | (({16'h0000, reqWdata} << laneShift) & laneMask);
    case (reqSize)
      S_BYTE:  loadVal = {{24{reqSigned & laneWord[7]}},  laneWord[7:0]};
      S_HALF:  loadVal = {{16{reqSigned & laneWord[15]}}, laneWord[15:0]};
      default: loadVal = mem_rdata;
    endcase
  end

  // Request sequencer: accept, read, optional write, then hold the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      reqType   <= T_FETCH;
      reqSize   <= S_BYTE;
      reqSigned <= 1'b0;
      reqOff    <= 2'b00;
      reqWdata  <= 16'h0000;
      resp_err  <= 1'b0;
      rdata     <= 32'h0;
      ir        <= 32'h0;
      mem_adr   <= 32'h0;
      mem_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            reqType   <= req_type;
            reqSize   <= req_size;
            reqSigned <= req_signed;
            reqOff    <= req_addr[1:0];
            reqWdata  <= req_wdata[15:0];
            resp_err  <= reqErr;
            rdata     <= 32'h0;
            if (reqErr) begin
              state <= RESP;
            end else begin
              mem_adr <= {req_addr[31:2], 2'b00};
              if (req_type == T_STORE && req_size == S_WORD) begin
                mem_wdata <= req_wdata;
                state     <= WR;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: begin
          if (reqType == T_FETCH) begin
            ir    <= mem_rdata;
            rdata <= mem_rdata;
            state <= RESP;
          end else if (reqType == T_LOAD) begin
            rdata <= loadVal;
            state <= RESP;
          end else begin
            mem_wdata <= mergeVal;
            state     <= WR;
          end
        end
        WR: begin
          rdata <= 32'h0;
          state <= RESP;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a big-endian word memory model.
// Checks reset state, load extension, read-modify-write stores, errors, response hold, mid-write reset.
// Response is held by keeping resp_ready low until latency has been measured.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_type;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_err;
  logic [31:0] rdata;
  logic [31:0] ir;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [31:0] mem_rdata;

  logic [31:0] memw [0:16383];
  int          wrCount = 0;
  logic [31:0] lastW = 32'h0;

  int nCompared = 0;
  int nMismatched = 0;

  mem_access_unit #(.MEM_BYTES(65536)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err),
    .rdata(rdata), .ir(ir),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Backing memory: combinational word read, word write on the clock edge.
  assign mem_rdata = memw[mem_adr[15:2]];

  always @(posedge clk) begin
    if (mem_write) begin
      memw[mem_adr[15:2]] <= mem_wdata;
      lastW   <= mem_wdata;
      wrCount = wrCount + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, measure cycles to resp_valid, capture response, then complete the handshake.
  task automatic doReq(input logic [1:0] t, input logic [1:0] s, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic err, output logic [31:0] rd);
    logic v;
    @(negedge clk);
    req_type = t; req_size = s; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; v = 1'b0; err = 1'b0; rd = 32'h0;
    while (!v && lat < 20) begin
      @(negedge clk);
      v = resp_valid; err = resp_err; rd = rdata;
      @(posedge clk);
      lat++;
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  // Load: check latency, data, no error and no memory write.
  task automatic loadCheck(input string tag, input logic [1:0] s, input logic sg,
                           input logic [31:0] a, input logic [31:0] exp);
    int lat; logic err; logic [31:0] rd; int wc;
    wc = wrCount;
    doReq(2'b01, s, sg, a, 32'h0, lat, err, rd);
    check({tag, "_lat"}, 32'(lat), 32'd2);
    check({tag, "_data"}, rd, exp);
    check({tag, "_err"}, {31'b0, err}, 32'd0);
    check({tag, "_nowr"}, 32'(wrCount - wc), 32'd0);
  endtask

  // Store: check latency, single write pulse and written word.
  task automatic storeCheck(input string tag, input logic [1:0] s, input logic [31:0] a,
                            input logic [31:0] wd, input int expLat, input logic [31:0] expW);
    int lat; logic err; logic [31:0] rd; int wc;
    wc = wrCount;
    doReq(2'b10, s, 1'b0, a, wd, lat, err, rd);
    check({tag, "_lat"}, 32'(lat), 32'(expLat));
    check({tag, "_wrcnt"}, 32'(wrCount - wc), 32'd1);
    check({tag, "_wdata"}, lastW, expW);
    check({tag, "_rdata"}, rd, 32'h0);
    check({tag, "_err"}, {31'b0, err}, 32'd0);
  endtask

  // Rejected request: 1-cycle error response, zero data, memory untouched.
  task automatic errCheck(input string tag, input logic [1:0] t, input logic [1:0] s,
                          input logic [31:0] a);
    int lat; logic err; logic [31:0] rd; int wc;
    wc = wrCount;
    doReq(t, s, 1'b0, a, 32'hFFFF_FFFF, lat, err, rd);
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check({tag, "_err"}, {31'b0, err}, 32'd1);
    check({tag, "_rdata"}, rd, 32'h0);
    check({tag, "_nowr"}, 32'(wrCount - wc), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) memw[i] = 32'h0;
    memw[0] = 32'hDEADBEEF;
    memw[4] = 32'h11223344;
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_type = 2'b00; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

    // Reset state
    #12;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_mem_write", {31'b0, mem_write}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_mem_adr", mem_adr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Word load
    loadCheck("lw10", 2'b10, 1'b0, 32'h10, 32'h11223344);

    // Byte/half extension on both lanes
    memw[4] = 32'h55667784;
    loadCheck("lb13", 2'b00, 1'b1, 32'h13, 32'hFFFFFF84);
    loadCheck("lbu13", 2'b00, 1'b0, 32'h13, 32'h00000084);
    loadCheck("lb11", 2'b00, 1'b1, 32'h11, 32'h00000066);
    memw[4] = 32'h55668433;
    loadCheck("lh12", 2'b01, 1'b1, 32'h12, 32'hFFFF8433);
    loadCheck("lhu12", 2'b01, 1'b0, 32'h12, 32'h00008433);
    loadCheck("lh10", 2'b01, 1'b1, 32'h10, 32'h00005566);

    // Stores: sub-word read-modify-write and whole word
    memw[4] = 32'h11223344;
    storeCheck("sb11", 2'b00, 32'h11, 32'h000000AB, 3, 32'h11AB3344);
    loadCheck("lw10_sb", 2'b10, 1'b0, 32'h10, 32'h11AB3344);
    storeCheck("sh12", 2'b01, 32'h12, 32'h1234BEEF, 3, 32'h11ABBEEF);
    storeCheck("sw20", 2'b10, 32'h20, 32'hCAFEF00D, 2, 32'hCAFEF00D);
    check("sw20_mem", memw[8], 32'hCAFEF00D);

    // Errors
    errCheck("err_lw0e", 2'b01, 2'b10, 32'h0E);
    errCheck("err_sh11", 2'b10, 2'b01, 32'h11);
    errCheck("err_lw10000", 2'b01, 2'b10, 32'h10000);
    errCheck("err_type11", 2'b11, 2'b10, 32'h10);
    errCheck("err_size11", 2'b01, 2'b11, 32'h10);
    check("err_mem_unchanged", memw[4], 32'h11ABBEEF);
    loadCheck("lw10_after_err", 2'b10, 1'b0, 32'h10, 32'h11ABBEEF);

    // Fetch with response held for 5 cycles
    @(negedge clk);
    req_type = 2'b00; req_size = 2'b11; req_addr = 32'h0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("fetch_hold_valid", {31'b0, resp_valid}, 32'd1);
      check("fetch_hold_ready", {31'b0, req_ready}, 32'd0);
      check("fetch_hold_ir", ir, 32'hDEADBEEF);
      check("fetch_hold_rdata", rdata, 32'hDEADBEEF);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check("fetch_done_ready", {31'b0, req_ready}, 32'd1);
    check("fetch_done_valid", {31'b0, resp_valid}, 32'd0);
    check("fetch_err", {31'b0, resp_err}, 32'd0);

    // Reset during the write cycle of a byte store
    begin
      int wc;
      wc = wrCount;
      @(negedge clk);
      req_type = 2'b10; req_size = 2'b00; req_addr = 32'h13; req_wdata = 32'h77; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 check("mid_wr_write", {31'b0, mem_write}, 32'd1);
      rst = 1'b1;
      #1 check("mid_wr_drop", {31'b0, mem_write}, 32'd0);
      @(posedge clk);
      @(negedge clk); rst = 1'b0;
      #1;
      check("mid_wr_ready", {31'b0, req_ready}, 32'd1);
      check("mid_wr_ir", ir, 32'h0);
      check("mid_wr_mem", memw[4], 32'h11ABBEEF);
      check("mid_wr_cnt", 32'(wrCount - wc), 32'd0);
    end
    loadCheck("lw10_after_rst", 2'b10, 1'b0, 32'h10, 32'h11ABBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
